alg_unit: RTL and testbench

Multi-cycle integer multiply/divide unit in the EX stage of the LC-3b pipeline. It consumes the decoder's `load_alg_reg` and `op_x_bits` packet fields, together with the forwarded operands, and runs a 16-step shift-add multiply or restoring divide. It holds the pipeline while computing and then keeps the 32-bit result in two registers. The EX result mux reads those registers through `alu_res_sel`: 4'b1001 selects `res_lo` (product low / quotient), and 4'b1010 selects `res_hi` (product high / remainder).

---
 rtl/alg_unit.sv | 129 ++++++++++++
 tb/tb_alg_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alg_unit.sv
// Multi-cycle unsigned 16-step shift-add multiply / restoring divide for the EX stage.
// Holds the pipeline while busy and keeps the 32-bit result in res_hi/res_lo until the next completion.
module alg_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op_x_bits,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [4:0] LAST_STEP = 5'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_r_q, b_r_d;
  logic             op_r_q, op_r_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;

  logic             valid_op;
  logic             accept;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] q_step;

  assign valid_op = (op_x_bits == OP_MUL) | (op_x_bits == OP_DIV);
  assign accept   = (state_q != S_RUN) & start & valid_op & ~flush;

  // One iteration of the datapath; op_r_q=1 selects divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[WIDTH-1:0]} + (q_q[0] ? {1'b0, b_r_q} : '0);
    div_sh   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, b_r_q};
    acc_step = {1'b0, mul_sum[WIDTH:1]};
    q_step   = {mul_sum[0], q_q[WIDTH-1:1]};
    if (op_r_q) begin
      if (!div_diff[WIDTH+1]) begin
        acc_step = div_diff[WIDTH:0];
        q_step   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = div_sh;
        q_step   = {q_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    q_d      = q_q;
    b_r_d    = b_r_q;
    op_r_d   = op_r_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    case (state_q)
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_step;
          q_d   = q_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_STEP) begin
            res_lo_d = q_step;
            res_hi_d = acc_step[WIDTH-1:0];
            state_d  = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          q_d     = opa;
          b_r_d   = opb;
          acc_d   = '0;
          cnt_d   = '0;
          op_r_d  = (op_x_bits == OP_DIV);
          state_d = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      q_q      <= '0;
      b_r_q    <= '0;
      op_r_q   <= 1'b0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      b_r_q    <= b_r_d;
      op_r_q   <= op_r_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign stall  = rst_n & ((state_q == S_RUN) | accept);
  assign done   = (state_q == S_DONE);
  assign res_lo = res_lo_q;
  assign res_hi = res_hi_q;

endmodule

// File: tb/tb_alg_unit.sv
// Directed bench for alg_unit: multiply, divide, back-to-back, ignored op, flush and mid-run reset.
module tb_alg_unit;

  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b001;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op_x_bits;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        flush;
  logic        stall;
  logic        done;
  logic [15:0] res_lo;
  logic [15:0] res_hi;

  int errors = 0;
  int checks = 0;
  int lat;
  int stall_cycles;

  alg_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_x_bits(op_x_bits),
    .opa(opa), .opb(opb), .flush(flush), .stall(stall), .done(done),
    .res_lo(res_lo), .res_hi(res_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns in the DONE cycle with start still asserted.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1; op_x_bits = op; opa = a; opb = b;
    #1;
    check("stall_cycle0", stall, 1'b1);
    stall_cycles = 1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!done && stall) stall_cycles++;
    end while (!done && lat < 40);
    check("latency", lat, 17);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_x_bits = OP_SUB; opa = '0; opb = '0; flush = 1'b0;
    #2;
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res", {res_hi, res_lo}, 32'h0);
    start = 1'b1; op_x_bits = OP_MUL;
    #1;
    check("rst_stall_forced", stall, 1'b0);
    start = 1'b0;
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_done", done, 1'b0);

    // 0x1234 * 0x0010
    run_op(OP_MUL, 16'h1234, 16'h0010);
    start = 1'b0; #1;
    check("mul1_stall_total", stall_cycles, 17);
    check("mul1_done_stall", stall, 1'b0);
    check("mul1_res", {res_hi, res_lo}, 32'h0001_2340);

    // 0xFFFF * 0xFFFF then back-to-back 3 * 5 from DONE
    @(posedge clk); #1;
    run_op(OP_MUL, 16'hFFFF, 16'hFFFF);
    check("mul2_res", {res_hi, res_lo}, 32'hFFFE_0001);
    run_op(OP_MUL, 16'h0003, 16'h0005);
    start = 1'b0; #1;
    check("b2b_res", {res_hi, res_lo}, 32'h0000_000F);
    @(posedge clk); #1;
    check("b2b_done_pulse", done, 1'b0);

    // 100 / 7
    run_op(OP_DIV, 16'h0064, 16'h0007);
    start = 1'b0; #1;
    check("div1_res", {res_hi, res_lo}, 32'h0002_000E);
    @(posedge clk); #1;

    // divide by zero
    run_op(OP_DIV, 16'h1234, 16'h0000);
    start = 1'b0; #1;
    check("divz_res", {res_hi, res_lo}, 32'h1234_FFFF);
    @(posedge clk); #1;

    // unsupported op is ignored
    start = 1'b1; op_x_bits = OP_SUB; opa = 16'h5555; opb = 16'h0003;
    #1;
    check("sub_stall", stall, 1'b0);
    @(posedge clk); #1;
    check("sub_stall_after", stall, 1'b0);
    start = 1'b0;
    @(posedge clk); #1;
    check("sub_no_done", done, 1'b0);
    check("sub_res_kept", {res_hi, res_lo}, 32'h1234_FFFF);

    // flush in RUN cycle 5 with start still held
    start = 1'b1; op_x_bits = OP_MUL; opa = 16'h00FF; opb = 16'h00FF;
    #1;
    check("fl_stall0", stall, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("fl_run_stall", stall, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    #1;
    check("fl_idle_stall", stall, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) check("fl_no_done", done, 1'b0);
    end
    check("fl_done_low", done, 1'b0);
    check("fl_res_kept", {res_hi, res_lo}, 32'h1234_FFFF);

    // flush and start together
    start = 1'b1; flush = 1'b1; op_x_bits = OP_DIV; opa = 16'h0010; opb = 16'h0002;
    #1;
    check("fs_stall", stall, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    check("fs_not_running", stall, 1'b0);

    // asynchronous reset in RUN cycle 8
    @(posedge clk); #1;
    start = 1'b1; op_x_bits = OP_MUL; opa = 16'h0100; opb = 16'h0100;
    repeat (8) @(posedge clk);
    #2;
    check("pre_rst_stall", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_res", {res_hi, res_lo}, 32'h0);
    start = 1'b0;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_stall", stall, 1'b0);

    // 9 / 2 after reset
    run_op(OP_DIV, 16'h0009, 16'h0002);
    start = 1'b0; #1;
    check("div2_res", {res_hi, res_lo}, 32'h0001_0004);
    @(posedge clk); #1;
    check("div2_idle", done, 1'b0);
    check("div2_res_hold", {res_hi, res_lo}, 32'h0001_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
